pic16_alu: RTL and testbench

- 8-bit ALU and working register (W) for the PIC16-compatible core.
- Combinationally computes result and STATUS flag candidates from the operand bus FI, W, the carry-in, the 5-bit opcode CB and the bit index B.
- Holds W internally and loads it from the result when WE is asserted.
- The core owns STATUS, the data memory and all write-enables for them; this block only supplies values.

---
 rtl/pic16_alu.sv | 135 +++++++++++++
 tb/tb_pic16_alu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic16_alu.sv
// PIC16-compatible 8-bit ALU with internal working register W.
// Optional debug port WREG is enabled by defining ALU_WREG_PORT_EN.
module pic16_alu (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [4:0] CB,
    input  logic       WE,
    input  logic [2:0] B,
    input  logic [7:0] FI,
    output logic [7:0] FO,
    input  logic       CI,
    output logic       CO,
    output logic       DC,
    output logic       Z
`ifdef ALU_WREG_PORT_EN
    ,
    output logic [7:0] WREG
`endif
);

    localparam logic [3:0] OP_MOVWF  = 4'b0000;
    localparam logic [3:0] OP_CLR    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;
    localparam logic [3:0] OP_IOR    = 4'b0100;
    localparam logic [3:0] OP_AND    = 4'b0101;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_ADD    = 4'b0111;
    localparam logic [3:0] OP_MOV    = 4'b1000;
    localparam logic [3:0] OP_COM    = 4'b1001;
    localparam logic [3:0] OP_INC    = 4'b1010;
    localparam logic [3:0] OP_DECFSZ = 4'b1011;
    localparam logic [3:0] OP_RRF    = 4'b1100;
    localparam logic [3:0] OP_RLF    = 4'b1101;
    localparam logic [3:0] OP_SWAP   = 4'b1110;
    localparam logic [3:0] OP_INCFSZ = 4'b1111;

    localparam logic [1:0] BOP_BCF = 2'b00;
    localparam logic [1:0] BOP_BSF = 2'b01;

    logic [7:0] r_w;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [4:0] w_nib_sum;
    logic [7:0] w_mask;
    logic [7:0] w_fo;
    logic       w_co;
    logic       w_dc;
    logic       w_z;
    logic       w_bit_test;

    // W register: async clear, loads the ALU result when enabled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_w <= 8'h00;
        end else if (WE) begin
            r_w <= w_fo;
        end else begin
            r_w <= r_w;
        end
    end

    assign w_sum      = {1'b0, FI} + {1'b0, r_w};
    assign w_diff     = {1'b0, FI} - {1'b0, r_w};
    assign w_nib_sum  = {1'b0, FI[3:0]} + {1'b0, r_w[3:0]};
    assign w_mask     = 8'h01 << B;
    assign w_bit_test = (CB[4:3] == 2'b11);

    // Result and flag candidates; carry passes CI through unless the op defines it.
    always_comb begin
        w_fo = 8'h00;
        w_co = CI;
        w_dc = 1'b0;
        if (CB[4]) begin
            case (CB[3:2])
                BOP_BCF: w_fo = FI & ~w_mask;
                BOP_BSF: w_fo = FI | w_mask;
                default: w_fo = FI;
            endcase
        end else begin
            case (CB[3:0])
                OP_MOVWF:  w_fo = r_w;
                OP_CLR:    w_fo = 8'h00;
                OP_SUB: begin
                    w_fo = w_diff[7:0];
                    w_co = ~w_diff[8];
                    w_dc = (FI[3:0] >= r_w[3:0]);
                end
                OP_DEC:    w_fo = FI - 8'h01;
                OP_IOR:    w_fo = FI | r_w;
                OP_AND:    w_fo = FI & r_w;
                OP_XOR:    w_fo = FI ^ r_w;
                OP_ADD: begin
                    w_fo = w_sum[7:0];
                    w_co = w_sum[8];
                    w_dc = w_nib_sum[4];
                end
                OP_MOV:    w_fo = FI;
                OP_COM:    w_fo = ~FI;
                OP_INC:    w_fo = FI + 8'h01;
                OP_DECFSZ: w_fo = FI - 8'h01;
                OP_RRF: begin
                    w_fo = {CI, FI[7:1]};
                    w_co = FI[0];
                end
                OP_RLF: begin
                    w_fo = {FI[6:0], CI};
                    w_co = FI[7];
                end
                OP_SWAP:   w_fo = {FI[3:0], FI[7:4]};
                OP_INCFSZ: w_fo = FI + 8'h01;
                default:   w_fo = 8'h00;
            endcase
        end
    end

    // Bit tests report the tested bit inverted so the core can skip on Z.
    always_comb begin
        if (w_bit_test) begin
            w_z = ~FI[B];
        end else begin
            w_z = (w_fo == 8'h00);
        end
    end

    assign FO = w_fo;
    assign CO = w_co;
    assign DC = w_dc;
    assign Z  = w_z;

`ifdef ALU_WREG_PORT_EN
    assign WREG = r_w;
`endif

endmodule

// File: tb/tb_pic16_alu.sv
// Self-checking bench for pic16_alu: directed test-plan vectors plus randomized
// operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pic16_alu;

    logic       CLK;
    logic       nRST;
    logic [4:0] CB;
    logic       WE;
    logic [2:0] B;
    logic [7:0] FI;
    logic [7:0] FO;
    logic       CI;
    logic       CO;
    logic       DC;
    logic       Z;
`ifdef ALU_WREG_PORT_EN
    logic [7:0] WREG;
`endif

    int n_cmp;
    int n_fail;

    pic16_alu dut (
        .CLK  (CLK),
        .nRST (nRST),
        .CB   (CB),
        .WE   (WE),
        .B    (B),
        .FI   (FI),
        .FO   (FO),
        .CI   (CI),
        .CO   (CO),
        .DC   (DC),
        .Z    (Z)
`ifdef ALU_WREG_PORT_EN
        ,
        .WREG (WREG)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: returns {fo[7:0], co, dc, z} from plain integer arithmetic.
    function automatic logic [10:0] ref_alu(input logic [4:0] cb, input int fi,
                                            input int w, input int ci, input int b);
        int fo;
        int co;
        int dc;
        int z;
        int bitval;
        co = ci;
        dc = 0;
        fo = 0;
        bitval = 1 << b;
        if (cb >= 16) begin
            if (cb / 4 == 4)      fo = (fi / bitval) % 2 == 1 ? fi - bitval : fi;
            else if (cb / 4 == 5) fo = (fi / bitval) % 2 == 0 ? fi + bitval : fi;
            else                  fo = fi;
        end else begin
            case (int'(cb))
                0:  fo = w;
                1:  fo = 0;
                2:  begin fo = fi - w; co = (fi >= w); dc = ((fi % 16) >= (w % 16)); end
                3:  fo = fi - 1;
                4:  fo = fi | w;
                5:  fo = fi & w;
                6:  fo = fi ^ w;
                7:  begin fo = fi + w; co = (fi + w > 255); dc = ((fi % 16) + (w % 16) > 15); end
                8:  fo = fi;
                9:  fo = 255 - fi;
                10: fo = fi + 1;
                11: fo = fi - 1;
                12: begin fo = ci * 128 + fi / 2; co = fi % 2; end
                13: begin fo = (fi * 2) % 256 + ci; co = fi / 128; end
                14: fo = (fi % 16) * 16 + fi / 16;
                default: fo = fi + 1;
            endcase
        end
        fo = (fo + 512) % 256;
        if (cb >= 24) z = ((fi / bitval) % 2 == 0);
        else          z = (fo == 0);
        return {fo[7:0], co[0], dc[0], z[0]};
    endfunction

    task automatic load_w(input logic [7:0] val);
        CB = 5'b01000;
        FI = val;
        WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        WE = 1'b0; CB = 5'b00000; FI = 8'h00; CI = 1'b0; B = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (FO !== 8'h00 || Z !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_w: FO=%h Z=%b, required FO=00 Z=1", FO, Z);
        end
        nRST = 1'b1;
        load_w(8'h5A);
        CB = 5'b00000;
        #1;
        n_cmp++;
        if (FO !== 8'h5A || Z !== 1'b0) begin
            n_fail++;
            $display("FAIL movlw: W=%h Z=%b, required W=5a Z=0", FO, Z);
        end
    endtask

    typedef struct packed {
        logic [4:0] cb;
        logic [7:0] w;
        logic [7:0] fi;
        logic       ci;
        logic [2:0] b;
        logic [7:0] fo;
        logic       co;
        logic       dc;
        logic       z;
    } vec_t;

    task automatic test_directed();
        vec_t v [0:13];
        v[0]  = '{5'b00111, 8'h5A, 8'hA6, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1};
        v[1]  = '{5'b00010, 8'h10, 8'h0F, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
        v[2]  = '{5'b00010, 8'h10, 8'h10, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1};
        v[3]  = '{5'b01100, 8'h00, 8'h81, 1'b0, 3'd0, 8'h40, 1'b1, 1'b0, 1'b0};
        v[4]  = '{5'b01101, 8'h00, 8'h81, 1'b1, 3'd0, 8'h03, 1'b1, 1'b0, 1'b0};
        v[5]  = '{5'b01110, 8'h00, 8'h3C, 1'b0, 3'd0, 8'hC3, 1'b0, 1'b0, 1'b0};
        v[6]  = '{5'b10000, 8'h00, 8'hFF, 1'b0, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b0};
        v[7]  = '{5'b10100, 8'h00, 8'h00, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0};
        v[8]  = '{5'b11000, 8'h00, 8'h08, 1'b0, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0};
        v[9]  = '{5'b11100, 8'h00, 8'hF7, 1'b0, 3'd3, 8'hF7, 1'b0, 1'b0, 1'b1};
        v[10] = '{5'b01010, 8'h00, 8'hFF, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        v[11] = '{5'b01011, 8'h00, 8'h01, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        v[12] = '{5'b00011, 8'h00, 8'h00, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0};
        v[13] = '{5'b00001, 8'h33, 8'hAB, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            load_w(v[i].w);
            CB = v[i].cb; FI = v[i].fi; CI = v[i].ci; B = v[i].b;
            #1;
            n_cmp++;
            if (FO !== v[i].fo || CO !== v[i].co || DC !== v[i].dc || Z !== v[i].z) begin
                n_fail++;
                $display("FAIL directed[%0d] cb=%b: FO=%h CO=%b DC=%b Z=%b, required FO=%h CO=%b DC=%b Z=%b",
                         i, v[i].cb, FO, CO, DC, Z, v[i].fo, v[i].co, v[i].dc, v[i].z);
            end
        end
        // ADD result written back to W.
        load_w(8'h5A);
        CB = 5'b00111; FI = 8'hA6; WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0; CB = 5'b00000;
        #1;
        n_cmp++;
        if (FO !== 8'h00) begin
            n_fail++;
            $display("FAIL add_writeback: W=%h, required W=00", FO);
        end
    endtask

    task automatic test_async_reset();
        load_w(8'h77);
        CB = 5'b00000;
        #1;
        n_cmp++;
        if (FO !== 8'h77) begin
            n_fail++;
            $display("FAIL preload_77: W=%h, required 77", FO);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (FO !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: W=%h, required 00 before any clock edge", FO);
        end
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        int w_model;
        logic [10:0] exp_v;
        CB = 5'b01000; FI = 8'h00; WE = 1'b1;
        @(posedge CLK);
        #1;
        w_model = 0;
        for (int i = 0; i < 300; i++) begin
            CB = 5'($urandom_range(0, 31));
            FI = 8'($urandom_range(0, 255));
            CI = 1'($urandom_range(0, 1));
            B  = 3'($urandom_range(0, 7));
            WE = 1'($urandom_range(0, 1));
            #1;
            exp_v = ref_alu(CB, int'(FI), w_model, int'(CI), int'(B));
            n_cmp++;
            if ({FO, CO, DC, Z} !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] cb=%b fi=%h w=%h ci=%b b=%0d: FO/CO/DC/Z=%h/%b/%b/%b, required %h/%b/%b/%b",
                         i, CB, FI, w_model[7:0], CI, B, FO, CO, DC, Z,
                         exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            @(posedge CLK);
            if (WE) w_model = int'(exp_v[10:3]);
            #1;
`ifdef ALU_WREG_PORT_EN
            n_cmp++;
            if (WREG !== w_model[7:0]) begin
                n_fail++;
                $display("FAIL wreg[%0d]: WREG=%h, required %h", i, WREG, w_model[7:0]);
            end
`endif
        end
        WE = 1'b0;
        CB = 5'b00000;
        #1;
        n_cmp++;
        if (FO !== w_model[7:0]) begin
            n_fail++;
            $display("FAIL final_w: W=%h, required %h", FO, w_model[7:0]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        CB = 5'b00000; WE = 1'b0; B = 3'd0; FI = 8'h00; CI = 1'b0; nRST = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
